// File: rtl/temp_table_writer.sv
// temp_table_writer
// Generates the C-to-F and F-to-C conversion tables at run time and streams
// them over a valid/ready write port into the converter RAMs. Entries are
// produced incrementally with a quotient/remainder accumulator, so no
// multiplier or divider is needed.
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       asynchronous active-high reset
//   start_i     begin generation (sampled only in IDLE)
//   busy_o      high while a pass is in progress
//   done_o      one-cycle pulse after the final beat is accepted
//   wr_valid_o  write beat valid
//   wr_ready_i  sink accepts beat
//   wr_sel_o    0 = C-to-F table, 1 = F-to-C table
//   wr_addr_o   table index (input temperature)
//   wr_data_o   table entry (converted temperature, saturated)
module temp_table_writer #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OFFSET     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic                  wr_sel_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o
);

    // Quotient needs headroom so 9a/5 never wraps before saturation.
    localparam int unsigned QW = DATA_WIDTH + 2;
    localparam int unsigned RW = 4;

    localparam logic [QW:0]           DATA_MAX  = (QW+1)'(2**DATA_WIDTH - 1);
    localparam logic [QW:0]           OFFSET_Q  = (QW+1)'(OFFSET);
    localparam logic [ADDR_WIDTH:0]   OFFSET_A  = (ADDR_WIDTH+1)'(OFFSET);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        FILL_F,
        FILL_C,
        DONE
    } state_t;

    state_t                state, state_n;
    logic [QW-1:0]         q, q_n;
    logic [RW-1:0]         r, r_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  valid_n;
    logic                  sel_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  xfer;

    // Clamp an accumulator value to the largest representable entry.
    function automatic logic [DATA_WIDTH-1:0] clamp(input logic [QW:0] v);
        if (v > DATA_MAX) begin
            return '1;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    assign xfer = wr_valid_o && wr_ready_i;

    // State, accumulators and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            q          <= '0;
            r          <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_sel_o   <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
        end else begin
            state      <= state_n;
            q          <= q_n;
            r          <= r_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            wr_valid_o <= valid_n;
            wr_sel_o   <= sel_n;
            wr_addr_o  <= addr_n;
            wr_data_o  <= data_n;
        end
    end

    // Next-state, accumulator stepping and next output values.
    always_comb begin
        state_n = state;
        q_n     = q;
        r_n     = r;
        busy_n  = busy_o;
        done_n  = 1'b0;
        valid_n = wr_valid_o;
        sel_n   = wr_sel_o;
        addr_n  = wr_addr_o;
        data_n  = wr_data_o;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_n = FILL_F;
                    busy_n  = 1'b1;
                    valid_n = 1'b1;
                    sel_n   = 1'b0;
                    addr_n  = '0;
                    q_n     = '0;
                    r_n     = '0;
                    data_n  = clamp(OFFSET_Q);
                end
            end

            FILL_F: begin
                if (xfer) begin
                    if (wr_addr_o == ADDR_LAST) begin
                        // Switch tables without a bubble.
                        state_n = FILL_C;
                        sel_n   = 1'b1;
                        addr_n  = '0;
                        q_n     = '0;
                        r_n     = '0;
                        data_n  = '0;
                    end else begin
                        // 9(a+1) = 5q + r + 9: carry when r+4 reaches 5.
                        addr_n = wr_addr_o + ADDR_WIDTH'(1);
                        if (r != '0) begin
                            q_n = q + QW'(2);
                            r_n = r - RW'(1);
                        end else begin
                            q_n = q + QW'(1);
                            r_n = r + RW'(4);
                        end
                        data_n = clamp({1'b0, q_n} + OFFSET_Q);
                    end
                end
            end

            FILL_C: begin
                if (xfer) begin
                    if (wr_addr_o == ADDR_LAST) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        valid_n = 1'b0;
                        sel_n   = 1'b0;
                        addr_n  = '0;
                        data_n  = '0;
                    end else begin
                        addr_n = wr_addr_o + ADDR_WIDTH'(1);
                        // Accumulate 5(a-OFFSET) = 9q + r once at or above the offset.
                        if ({1'b0, wr_addr_o} >= OFFSET_A) begin
                            if (r >= RW'(4)) begin
                                q_n = q + QW'(1);
                                r_n = r - RW'(4);
                            end else begin
                                r_n = r + RW'(5);
                            end
                        end
                        data_n = clamp({1'b0, q_n});
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
